// File: rtl/i_cache_fill_fsm.sv
// Instruction-cache miss handler: issues eight back-to-back word reads for the
// missing block, writes each returned word into the data array, then validates the tag.
module i_cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic [15:0] fill_block_addr,
  output logic        write_data_array,
  output logic [2:0]  data_word_offset,
  output logic [15:0] data_out,
  output logic        write_tag_array
);

  localparam logic [3:0] WORDS = 4'(BLOCK_WORDS);
  localparam logic [3:0] LAST  = 4'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, state_nxt;
  logic [11:0] base;
  logic [3:0]  issue_cnt, recv_cnt;
  logic        capture, issue_en, write_en, last_word;

  assign capture   = (state == IDLE) && miss_detected;
  assign issue_en  = (state == FILL) && (issue_cnt != WORDS);
  assign write_en  = (state == FILL) && memory_data_valid && (recv_cnt != WORDS);
  assign last_word = write_en && (recv_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_detected) state_nxt = FILL;
      FILL:    if (last_word)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else if (capture) begin
      base      <= miss_address[15:4];
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      if (issue_en) issue_cnt <= issue_cnt + 4'd1;
      if (write_en) recv_cnt  <= recv_cnt + 4'd1;
    end
  end

  // Once all requests are out the address parks on the last word rather than wrapping.
  always_comb begin
    fsm_busy         = (state == FILL);
    memory_read      = issue_en;
    memory_address   = {base, issue_cnt[2:0], 1'b0};
    if ((state == FILL) && !issue_en)
      memory_address = {base, LAST[2:0], 1'b0};
    fill_block_addr  = {base, 4'b0000};
    write_data_array = write_en;
    data_word_offset = write_en ? recv_cnt[2:0] : 3'd0;
    data_out         = memory_data;
    write_tag_array  = last_word;
  end

endmodule

// File: doc/i_cache_fill_fsm.md
# i_cache_fill_fsm

Miss-handling controller for the instruction cache. When the cache reports a miss, this block captures the missing block address and issues eight sequential word reads to the multi-cycle main memory. It counts the returning words and drives one data-array write per returned word, then a single tag-array write that validates the block. While it is busy the fetch stage stays stalled; the cache then hits on the refilled block and releases the stall.

## Interface
- BLOCK_WORDS, 8: 16-bit words per cache block. Only 8 is supported, giving 16-byte blocks and a 3-bit word offset.

- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- miss_detected  in  1  cache miss/stall indication for the current fetch
- miss_address  in  16  byte address of the missing fetch
- memory_data_valid  in  1  memory returns a word this cycle
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress
- memory_read  out  1  read request to memory this cycle
- memory_address  out  16  word address of the current request
- fill_block_addr  out  16  latched block base: {miss_address[15:4], 4'b0}
- write_data_array  out  1  write data_out into the data array this cycle
- data_word_offset  out  3  word within the block being written
- data_out  out  16  word to write; equals memory_data
- write_tag_array  out  1  write the tag of fill_block_addr with the valid bit set

## Operation
- States: IDLE, FILL.
- Registers:
  - base[15:4]
  - issue_cnt, 4 bits, 0..8
  - recv_cnt, 4 bits, 0..8
  - state
- IDLE:
  - fsm_busy=0; memory_read=0.
  - If miss_detected=1: latch base=miss_address[15:4]; clear both counters; go to FILL.
- FILL:
  - fsm_busy=1.
  - While issue_cnt<8: memory_read=1 and memory_address={base, issue_cnt[2:0], 1'b0}; issue_cnt increments each cycle.
  - When issue_cnt=8: memory_read=0. memory_address holds its last value and is don't-care.
- Word return (FILL only):
  - Each cycle with memory_data_valid=1 and recv_cnt<8: write_data_array=1, data_word_offset=recv_cnt[2:0], data_out=memory_data; recv_cnt increments.
  - All three are combinational from the inputs and current state.
- Completion:
  - In the cycle the 8th word is written (recv_cnt=7 with memory_data_valid=1), write_tag_array=1 as well.
  - Next state is IDLE.
- Ignored inputs:
  - miss_detected while in FILL, including the completion cycle.
  - memory_data_valid while in IDLE, or after 8 words have been received.
- Offset mapping: word offset n corresponds to byte address bits [3:1]=n, so the block is fully filled whichever word missed.
- fill_block_addr updates only on capture and holds between fills.

## Timing
- Reset (asynchronous): state=IDLE; counters=0; base=0. All outputs 0 except data_out, which follows memory_data.
- Reset asserted mid-FILL aborts the fill immediately. No tag write occurs, so the partially written block stays invalid.
- Capture: a miss seen in cycle t (IDLE) gives fsm_busy=1 and the first request (offset 0) in cycle t+1.
- Requests: in cycles t+1..t+8 with offsets 0..7, back-to-back and never stalled.
- Memory latency L: words return in cycles t+1+L .. t+8+L. Write completion and write_tag_array occur at t+8+L, and fsm_busy=0 at t+9+L.
- A new miss can be accepted at t+9+L at the earliest.
- Gaps in memory_data_valid only delay completion; recv_cnt does not advance in gap cycles.

## Test plan
- Reset mid-fill:
  - Stimulus: drop rst_n at cycle t+5 of a fill; release it; hold miss_detected=0.
  - Response: all outputs 0 immediately, and no write_tag_array ever asserts.
  - Then assert a fresh miss: the FSM starts cleanly, with the first memory_address = new base.
- Basic fill, L=4:
  - Stimulus: miss_address=0x1236 at cycle 0.
  - Response: memory_address 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - Returned data 0xA000+n is written with data_word_offset=n in cycles 5–12.
  - write_tag_array=1 only in cycle 12; fill_block_addr=0x1230; fsm_busy high in cycles 1–12 only.
- Gapped returns: same miss, memory_data_valid low in every other cycle. Exactly 8 data writes occur with offsets 0..7 in order, and the tag write coincides with the 8th.
- Ignored inputs during and after a fill:
  - miss_detected=1 with miss_address=0x4000 during FILL: no recapture, fill_block_addr stays 0x1230.
  - A spurious memory_data_valid in IDLE produces no write.
  - A 9th valid word after the 8th produces no write.
- Back-to-back misses: a second miss asserted in the completion cycle is ignored. The same miss held one cycle later is captured at t+9+L, and issue of offset 0 follows in the next cycle.
